gpr_write_sequencer: RTL and testbench
======================================

# gpr_write_sequencer

Registered, parametrised successor to the PIC16C5x register-file write decision logic. It latches the file address during the Q2 execute state and resolves direct, banked and indirect (INDF/FSR) addressing. It merges ALU flags into STATUS and commits GPR and STATUS writes as one-cycle registered strobes after the Q4 execute state. It sits between the execute-state sequencer/ALU and the banked register file, and provides a one-entry write-forward port for the following instruction's operand read.

## Interface
- `DATA_WIDTH`, 8: GPR, W and STATUS width (≥ 8).
- `FADDR_WIDTH`, 5: instruction file-address field width (IR[FADDR_WIDTH-1:0]).
- `BANK_BITS`, 2: FSR bank bits above the file field; 0 gives a flat file.
- `STATUS_ADDR`, 3: file address of STATUS.
- `GLOBAL_TOP`, 15: highest unbanked address (0..GLOBAL_TOP always map to bank 0).
- `clk` in 1: the one clock; all state updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `executeState` in `EX_STATE_BITS`: execute state code from define.v.
- `IR` in 12: current instruction; IR[5] is the d bit.
- `fsrIn` in DATA_WIDTH: current FSR value.
- `wRIn` in DATA_WIDTH: W register.
- `aluResultIn` in DATA_WIDTH: ALU result.
- `aluStatusIn` in `ALU_STATUS_WIDTH` (3): {Z, DC, C}.
- `gprStatusIn` in DATA_WIDTH: current STATUS contents.
- `flush` in 1: cancel the in-flight instruction (skip/branch).
- `gprWe` out 1: GPR write strobe.
- `gprWaddr` out BANK_BITS+FADDR_WIDTH: GPR write address.
- `gprWdata` out DATA_WIDTH: GPR write data.
- `statusWe` out 1: STATUS write strobe.
- `statusWdata` out DATA_WIDTH: STATUS write data.
- `fwdValid` out 1: forward entry holds a committed write.
- `fwdAddr` out BANK_BITS+FADDR_WIDTH: address of the last committed GPR/STATUS write.
- `fwdData` out DATA_WIDTH: data of the last committed GPR/STATUS write.
- `orphanErr` out 1: sticky; set by a Q4 GPR write with no latched address.

## Operation
- FSM states: IDLE, LATCHED, COMMIT. Reset forces IDLE and zeros every output, including `orphanErr` and the forward entry.
- Address resolution on the `EX_Q2` edge, with f = IR[FADDR_WIDTH-1:0]:
  - f ≠ 0 and f ≤ GLOBAL_TOP: addr = {0, f}.
  - f ≠ 0 and f > GLOBAL_TOP: addr = {fsrIn[FADDR_WIDTH+BANK_BITS-1:FADDR_WIDTH], f}.
  - f = 0 (INDF): apply the same two rules to f' = fsrIn[FADDR_WIDTH-1:0] with the same bank bits.
  - f = 0 and f' = 0: the address is marked null and any GPR write is dropped silently.
- The `EX_Q2` edge latches the address and moves IDLE/COMMIT → LATCHED.
- The Q4 edge decodes the data:
  - `EX_Q4_CLRF`: data 0, GPR write.
  - `EX_Q4_MOVWF`: data wRIn, GPR write.
  - `EX_Q4_BXF`: data aluResultIn, GPR write.
  - `EX_Q4_FSZ`, `EX_Q4_ELSE`: data aluResultIn, GPR write only if IR[5] = 1.
  - Any other state: no GPR write.
- STATUS on the Q4 edge:
  - `EX_Q4_CLRF`, `EX_Q4_CLRW`: {gprStatusIn[7:3], 1, gprStatusIn[1:0]}.
  - `EX_Q4_ALUXLW`, `EX_Q4_MOVF`, `EX_Q4_ELSE`: {gprStatusIn[7:3], aluStatusIn}.
  - Otherwise no STATUS write.
- STATUS-target merge: when a GPR write targets {any bank, STATUS_ADDR} and a STATUS write is also due, `gprWe` = 0. In that case `statusWdata` = {gpr data[7:3], flags}, where flags are aluStatusIn, or for CLRF the Z=1 pattern (CLRF STATUS → 0x04).
- A GPR write to STATUS with no STATUS update (MOVWF STATUS) goes out on `gprWe` only.
- Any Q4 edge moves to COMMIT and consumes the latch (back to IDLE after COMMIT).
- Orphan: a Q4 edge that needs a GPR write while in IDLE produces no GPR write and sets `orphanErr`. The STATUS write still occurs.
- `flush` = 1 on any edge cancels the latched address and any Q4 decode on that edge; next state is IDLE. A `flush` on the COMMIT-producing edge suppresses the commit.
- Forward entry: updated on every commit that has `gprWe` or a merged STATUS write; it holds until the next such commit or reset.

## Timing
- Commit latency: `gprWe`/`statusWe` are high for exactly one cycle, the cycle after the Q4 sample edge.
- `gprWaddr`/`gprWdata` are valid only while `gprWe` = 1 and read 0 otherwise. `statusWdata` likewise reads 0 unless `statusWe` = 1.
- `fwdValid`/`fwdAddr`/`fwdData` update in the same cycle that the strobes assert.
- A Q2 on the cycle directly after Q4 is legal (back-to-back instructions). The COMMIT strobes and the new latch coexist.
- Reset mid-operation: the next cycle is IDLE with all strobes 0 and no pending write.

## Test plan
- Direct write, bank-independent: Q2 with IR = 0x02A (MOVWF 0x0A), FSR = 0x60, W = 0x5A, then Q4_MOVWF → one-cycle gprWe, addr 0x0A, data 0x5A; fwdAddr = 0x0A.
- Banked indirect: IR f = 0 (INDF), FSR = 0x75, Q4_BXF, ALU = 0x81 → addr {2'b11, 5'h15}, data 0x81.
- Null and flush: FSR = 0x40 with INDF → no gprWe. Separately, flush asserted on the Q4 edge of a valid write → no strobes, FSM IDLE.
- STATUS merge: ADDWF STATUS,1 with gprStatusIn = 0x18, ALU = 0xF0, flags 3'b101 → gprWe = 0, statusWe = 1, data 0xF5. Separately, CLRF STATUS → statusWdata 0x04.
- d-bit: ELSE state, IR[5] = 0 → gprWe = 0 and statusWe = 1 with the ALU flags. Q4 with no preceding Q2 → orphanErr = 1; rst clears it to 0.
- Back-to-back: Q2, Q4, Q2, Q4 on consecutive edges → two commits with the correct, independent addresses and no lost latch.

Source files
------------

// File: rtl/gpr_write_sequencer.sv
// Register-file write sequencer: latches the file address at Q2, decodes GPR/STATUS
// writes at Q4 and issues them as one-cycle registered strobes plus a forward entry.
module gpr_write_sequencer #(
    parameter int DATA_WIDTH       = 8,
    parameter int FADDR_WIDTH      = 5,
    parameter int BANK_BITS        = 2,
    parameter int STATUS_ADDR      = 3,
    parameter int GLOBAL_TOP       = 15,
    parameter int EX_STATE_BITS    = 4,
    parameter int ALU_STATUS_WIDTH = 3,
    parameter logic [EX_STATE_BITS-1:0] EX_Q2        = EX_STATE_BITS'(32'd1),
    parameter logic [EX_STATE_BITS-1:0] EX_Q4_CLRF   = EX_STATE_BITS'(32'd2),
    parameter logic [EX_STATE_BITS-1:0] EX_Q4_CLRW   = EX_STATE_BITS'(32'd3),
    parameter logic [EX_STATE_BITS-1:0] EX_Q4_MOVWF  = EX_STATE_BITS'(32'd4),
    parameter logic [EX_STATE_BITS-1:0] EX_Q4_BXF    = EX_STATE_BITS'(32'd5),
    parameter logic [EX_STATE_BITS-1:0] EX_Q4_FSZ    = EX_STATE_BITS'(32'd6),
    parameter logic [EX_STATE_BITS-1:0] EX_Q4_ALUXLW = EX_STATE_BITS'(32'd7),
    parameter logic [EX_STATE_BITS-1:0] EX_Q4_MOVF   = EX_STATE_BITS'(32'd8),
    parameter logic [EX_STATE_BITS-1:0] EX_Q4_ELSE   = EX_STATE_BITS'(32'd9),
    parameter logic [EX_STATE_BITS-1:0] EX_Q4_NOP    = EX_STATE_BITS'(32'd10)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [EX_STATE_BITS-1:0]         executeState,
    input  logic [11:0]                      IR,
    input  logic [DATA_WIDTH-1:0]            fsrIn,
    input  logic [DATA_WIDTH-1:0]            wRIn,
    input  logic [DATA_WIDTH-1:0]            aluResultIn,
    input  logic [ALU_STATUS_WIDTH-1:0]      aluStatusIn,
    input  logic [DATA_WIDTH-1:0]            gprStatusIn,
    input  logic                             flush,
    output logic                             gprWe,
    output logic [BANK_BITS+FADDR_WIDTH-1:0] gprWaddr,
    output logic [DATA_WIDTH-1:0]            gprWdata,
    output logic                             statusWe,
    output logic [DATA_WIDTH-1:0]            statusWdata,
    output logic                             fwdValid,
    output logic [BANK_BITS+FADDR_WIDTH-1:0] fwdAddr,
    output logic [DATA_WIDTH-1:0]            fwdData,
    output logic                             orphanErr
);

    localparam int AW = BANK_BITS + FADDR_WIDTH;
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_LATCHED = 2'd1;
    localparam logic [1:0] S_COMMIT  = 2'd2;
    localparam logic [FADDR_WIDTH-1:0] GTOP   = FADDR_WIDTH'(GLOBAL_TOP);
    localparam logic [FADDR_WIDTH-1:0] STAT_F = FADDR_WIDTH'(STATUS_ADDR);

    logic [1:0]             state_r;
    logic [AW-1:0]          laddr_r;
    logic                   lnull_r;

    logic [FADDR_WIDTH-1:0] f_s;
    logic [FADDR_WIDTH-1:0] f_eff_s;
    logic [AW-1:0]          bank_off_s;
    logic [AW-1:0]          addr_s;
    logic                   null_s;

    logic                   is_q2_s;
    logic                   is_q4_s;
    logic                   need_gpr_s;
    logic [DATA_WIDTH-1:0]  gdata_s;
    logic                   status_due_s;
    logic [DATA_WIDTH-1:0]  snorm_s;
    logic [2:0]             mflags_s;

    logic                   have_addr_s;
    logic                   do_gpr_s;
    logic                   merge_s;
    logic                   gpr_fire_s;
    logic                   status_fire_s;
    logic                   orphan_s;
    logic [DATA_WIDTH-1:0]  sdata_s;
    logic                   unused_s;

    assign unused_s = ^{IR, gprStatusIn};

    // Address resolution: INDF (f = 0) substitutes the FSR low bits; high addresses take the FSR bank.
    always_comb begin
        f_s = IR[FADDR_WIDTH-1:0];
        if (f_s == '0) begin
            f_eff_s = fsrIn[FADDR_WIDTH-1:0];
        end else begin
            f_eff_s = f_s;
        end
        bank_off_s = AW'(fsrIn >> FADDR_WIDTH) << FADDR_WIDTH;
        null_s     = (f_eff_s == '0);
        if (f_eff_s > GTOP) begin
            addr_s = bank_off_s | AW'(f_eff_s);
        end else begin
            addr_s = AW'(f_eff_s);
        end
    end

    // Q4 decode of GPR data and STATUS update; mflags_s is the flag field used when the two merge.
    always_comb begin
        is_q2_s      = (executeState == EX_Q2);
        is_q4_s      = 1'b0;
        need_gpr_s   = 1'b0;
        gdata_s      = '0;
        status_due_s = 1'b0;
        snorm_s      = '0;
        mflags_s     = aluStatusIn;
        case (executeState)
            EX_Q4_CLRF: begin
                is_q4_s      = 1'b1;
                need_gpr_s   = 1'b1;
                status_due_s = 1'b1;
                snorm_s      = {gprStatusIn[DATA_WIDTH-1:3], 1'b1, gprStatusIn[1:0]};
                mflags_s     = 3'b100;
            end
            EX_Q4_CLRW: begin
                is_q4_s      = 1'b1;
                status_due_s = 1'b1;
                snorm_s      = {gprStatusIn[DATA_WIDTH-1:3], 1'b1, gprStatusIn[1:0]};
            end
            EX_Q4_MOVWF: begin
                is_q4_s    = 1'b1;
                need_gpr_s = 1'b1;
                gdata_s    = wRIn;
            end
            EX_Q4_BXF: begin
                is_q4_s    = 1'b1;
                need_gpr_s = 1'b1;
                gdata_s    = aluResultIn;
            end
            EX_Q4_FSZ: begin
                is_q4_s    = 1'b1;
                need_gpr_s = IR[5];
                gdata_s    = aluResultIn;
            end
            EX_Q4_ALUXLW, EX_Q4_MOVF: begin
                is_q4_s      = 1'b1;
                status_due_s = 1'b1;
                snorm_s      = {gprStatusIn[DATA_WIDTH-1:3], aluStatusIn};
            end
            EX_Q4_ELSE: begin
                is_q4_s      = 1'b1;
                need_gpr_s   = IR[5];
                gdata_s      = aluResultIn;
                status_due_s = 1'b1;
                snorm_s      = {gprStatusIn[DATA_WIDTH-1:3], aluStatusIn};
            end
            EX_Q4_NOP: begin
                is_q4_s = 1'b1;
            end
            default: begin
                is_q4_s = 1'b0;
            end
        endcase
    end

    // Commit decision: a GPR write aimed at STATUS is folded into the STATUS write when one is due.
    always_comb begin
        have_addr_s   = (state_r == S_LATCHED);
        do_gpr_s      = is_q4_s && !flush && need_gpr_s && have_addr_s && !lnull_r;
        merge_s       = do_gpr_s && status_due_s && (laddr_r[FADDR_WIDTH-1:0] == STAT_F);
        gpr_fire_s    = do_gpr_s && !merge_s;
        status_fire_s = is_q4_s && !flush && status_due_s;
        orphan_s      = is_q4_s && !flush && need_gpr_s && !have_addr_s;
        if (merge_s) begin
            sdata_s = {gdata_s[DATA_WIDTH-1:3], mflags_s};
        end else begin
            sdata_s = snorm_s;
        end
    end

    // Sequencer state and address latch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
            laddr_r <= '0;
            lnull_r <= 1'b1;
        end else if (flush) begin
            state_r <= S_IDLE;
            laddr_r <= '0;
            lnull_r <= 1'b1;
        end else if (is_q2_s) begin
            state_r <= S_LATCHED;
            laddr_r <= addr_s;
            lnull_r <= null_s;
        end else if (is_q4_s) begin
            state_r <= S_COMMIT;
        end else if (state_r == S_COMMIT) begin
            state_r <= S_IDLE;
        end
    end

    // Registered strobes, forward entry and sticky orphan flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            gprWe       <= 1'b0;
            gprWaddr    <= '0;
            gprWdata    <= '0;
            statusWe    <= 1'b0;
            statusWdata <= '0;
            fwdValid    <= 1'b0;
            fwdAddr     <= '0;
            fwdData     <= '0;
            orphanErr   <= 1'b0;
        end else begin
            gprWe       <= gpr_fire_s;
            gprWaddr    <= gpr_fire_s ? laddr_r : '0;
            gprWdata    <= gpr_fire_s ? gdata_s : '0;
            statusWe    <= status_fire_s;
            statusWdata <= status_fire_s ? sdata_s : '0;
            orphanErr   <= orphanErr | orphan_s;
            if (gpr_fire_s || merge_s) begin
                fwdValid <= 1'b1;
                fwdAddr  <= laddr_r;
                fwdData  <= merge_s ? sdata_s : gdata_s;
            end
        end
    end

endmodule

// File: tb/tb_gpr_write_sequencer.sv
// Directed bench for gpr_write_sequencer: expected commits are queued per step and
// popped for comparison after the sampling edge.
module tb_gpr_write_sequencer;

    localparam logic [3:0] NOP    = 4'd0;
    localparam logic [3:0] Q2     = 4'd1;
    localparam logic [3:0] CLRF   = 4'd2;
    localparam logic [3:0] CLRW   = 4'd3;
    localparam logic [3:0] MOVWF  = 4'd4;
    localparam logic [3:0] BXF    = 4'd5;
    localparam logic [3:0] FSZ    = 4'd6;
    localparam logic [3:0] ALUXLW = 4'd7;
    localparam logic [3:0] MOVF   = 4'd8;
    localparam logic [3:0] ELSE_S = 4'd9;
    localparam logic [3:0] Q4NOP  = 4'd10;

    typedef struct {
        logic       gwe;
        logic [6:0] wa;
        logic [7:0] wd;
        logic       swe;
        logic [7:0] sd;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] executeState = NOP;
    logic [11:0] IR = 12'h000;
    logic [7:0] fsrIn = 8'h00;
    logic [7:0] wRIn = 8'h00;
    logic [7:0] aluResultIn = 8'h00;
    logic [2:0] aluStatusIn = 3'b000;
    logic [7:0] gprStatusIn = 8'h00;
    logic       flush = 1'b0;
    logic       gprWe;
    logic [6:0] gprWaddr;
    logic [7:0] gprWdata;
    logic       statusWe;
    logic [7:0] statusWdata;
    logic       fwdValid;
    logic [6:0] fwdAddr;
    logic [7:0] fwdData;
    logic       orphanErr;

    int errors = 0;
    int checks = 0;
    exp_t sb[$];

    gpr_write_sequencer #(
        .DATA_WIDTH(8), .FADDR_WIDTH(5), .BANK_BITS(2), .STATUS_ADDR(3), .GLOBAL_TOP(15),
        .EX_STATE_BITS(4), .ALU_STATUS_WIDTH(3),
        .EX_Q2(Q2), .EX_Q4_CLRF(CLRF), .EX_Q4_CLRW(CLRW), .EX_Q4_MOVWF(MOVWF),
        .EX_Q4_BXF(BXF), .EX_Q4_FSZ(FSZ), .EX_Q4_ALUXLW(ALUXLW), .EX_Q4_MOVF(MOVF),
        .EX_Q4_ELSE(ELSE_S), .EX_Q4_NOP(Q4NOP)
    ) dut (
        .clk(clk), .rst(rst), .executeState(executeState), .IR(IR), .fsrIn(fsrIn),
        .wRIn(wRIn), .aluResultIn(aluResultIn), .aluStatusIn(aluStatusIn),
        .gprStatusIn(gprStatusIn), .flush(flush), .gprWe(gprWe), .gprWaddr(gprWaddr),
        .gprWdata(gprWdata), .statusWe(statusWe), .statusWdata(statusWdata),
        .fwdValid(fwdValid), .fwdAddr(fwdAddr), .fwdData(fwdData), .orphanErr(orphanErr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input string tag, input logic [3:0] st, input logic [11:0] ir,
                        input logic [7:0] fsr, input logic [7:0] w, input logic [7:0] alu,
                        input logic [2:0] fl, input logic [7:0] gs, input logic fsh,
                        input logic e_gwe, input logic [6:0] e_wa, input logic [7:0] e_wd,
                        input logic e_swe, input logic [7:0] e_sd);
        exp_t e;
        executeState = st;
        IR           = ir;
        fsrIn        = fsr;
        wRIn         = w;
        aluResultIn  = alu;
        aluStatusIn  = fl;
        gprStatusIn  = gs;
        flush        = fsh;
        e.gwe = e_gwe; e.wa = e_wa; e.wd = e_wd; e.swe = e_swe; e.sd = e_sd;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({tag, ".gprWe"}, 32'(gprWe), 32'(e.gwe));
        chk({tag, ".gprWaddr"}, 32'(gprWaddr), 32'(e.wa));
        chk({tag, ".gprWdata"}, 32'(gprWdata), 32'(e.wd));
        chk({tag, ".statusWe"}, 32'(statusWe), 32'(e.swe));
        chk({tag, ".statusWdata"}, 32'(statusWdata), 32'(e.sd));
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        executeState = NOP;
        flush = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk({tag, ".gprWe"}, 32'(gprWe), 32'd0);
        chk({tag, ".statusWe"}, 32'(statusWe), 32'd0);
        chk({tag, ".gprWaddr"}, 32'(gprWaddr), 32'd0);
        chk({tag, ".statusWdata"}, 32'(statusWdata), 32'd0);
        chk({tag, ".fwdValid"}, 32'(fwdValid), 32'd0);
        chk({tag, ".fwdAddr"}, 32'(fwdAddr), 32'd0);
        chk({tag, ".fwdData"}, 32'(fwdData), 32'd0);
        chk({tag, ".orphanErr"}, 32'(orphanErr), 32'd0);
    endtask

    initial begin
        do_reset("reset0");

        // Direct write to 0x0A, bank bits of FSR ignored
        step("mov_q2", Q2, 12'h02A, 8'h60, 8'h5A, 8'h00, 3'b000, 8'h00, 1'b0, 1'b0, 7'h00, 8'h00, 1'b0, 8'h00);
        step("mov_q4", MOVWF, 12'h02A, 8'h60, 8'h5A, 8'h00, 3'b000, 8'h00, 1'b0, 1'b1, 7'h0A, 8'h5A, 1'b0, 8'h00);
        chk("mov.fwdValid", 32'(fwdValid), 32'd1);
        chk("mov.fwdAddr", 32'(fwdAddr), 32'h0A);
        chk("mov.fwdData", 32'(fwdData), 32'h5A);
        step("mov_after", NOP, 12'h02A, 8'h60, 8'h5A, 8'h00, 3'b000, 8'h00, 1'b0, 1'b0, 7'h00, 8'h00, 1'b0, 8'h00);

        // Banked indirect: FSR 0x75 -> bank 3, offset 0x15
        step("ind_q2", Q2, 12'h020, 8'h75, 8'h00, 8'h00, 3'b000, 8'h00, 1'b0, 1'b0, 7'h00, 8'h00, 1'b0, 8'h00);
        step("ind_q4", BXF, 12'h020, 8'h75, 8'h00, 8'h81, 3'b000, 8'h00, 1'b0, 1'b1, 7'h75, 8'h81, 1'b0, 8'h00);
        chk("ind.fwdAddr", 32'(fwdAddr), 32'h75);
        chk("ind.fwdData", 32'(fwdData), 32'h81);

        // Null indirect address: write silently dropped, no orphan
        step("null_q2", Q2, 12'h020, 8'h40, 8'h33, 8'h00, 3'b000, 8'h00, 1'b0, 1'b0, 7'h00, 8'h00, 1'b0, 8'h00);
        step("null_q4", MOVWF, 12'h020, 8'h40, 8'h33, 8'h00, 3'b000, 8'h00, 1'b0, 1'b0, 7'h00, 8'h00, 1'b0, 8'h00);
        chk("null.orphanErr", 32'(orphanErr), 32'd0);
        chk("null.fwdData", 32'(fwdData), 32'h81);

        // Flush on the Q4 edge kills the commit and drops the latch
        step("fl_q2", Q2, 12'h02A, 8'h00, 8'h44, 8'h00, 3'b000, 8'h00, 1'b0, 1'b0, 7'h00, 8'h00, 1'b0, 8'h00);
        step("fl_q4", MOVWF, 12'h02A, 8'h00, 8'h44, 8'h00, 3'b000, 8'h00, 1'b1, 1'b0, 7'h00, 8'h00, 1'b0, 8'h00);
        step("fl_idle", NOP, 12'h02A, 8'h00, 8'h44, 8'h00, 3'b000, 8'h00, 1'b0, 1'b0, 7'h00, 8'h00, 1'b0, 8'h00);
        chk("fl.orphanErr", 32'(orphanErr), 32'd0);

        // Q4 with no latched address: orphan, STATUS still written
        step("orph_q4", ELSE_S, 12'h1EA, 8'h00, 8'h00, 8'h99, 3'b010, 8'h18, 1'b0, 1'b0, 7'h00, 8'h00, 1'b1, 8'h1A);
        chk("orph.orphanErr", 32'(orphanErr), 32'd1);
        step("orph_hold", NOP, 12'h000, 8'h00, 8'h00, 8'h00, 3'b000, 8'h00, 1'b0, 1'b0, 7'h00, 8'h00, 1'b0, 8'h00);
        chk("orph.sticky", 32'(orphanErr), 32'd1);
        do_reset("reset1");

        // ADDWF STATUS,1 merges into the STATUS write
        step("mrg_q2", Q2, 12'h1E3, 8'h00, 8'h00, 8'h00, 3'b000, 8'h18, 1'b0, 1'b0, 7'h00, 8'h00, 1'b0, 8'h00);
        step("mrg_q4", ELSE_S, 12'h1E3, 8'h00, 8'h00, 8'hF0, 3'b101, 8'h18, 1'b0, 1'b0, 7'h00, 8'h00, 1'b1, 8'hF5);
        chk("mrg.fwdValid", 32'(fwdValid), 32'd1);
        chk("mrg.fwdAddr", 32'(fwdAddr), 32'h03);
        chk("mrg.fwdData", 32'(fwdData), 32'hF5);

        // CLRF STATUS -> 0x04
        step("clrs_q2", Q2, 12'h063, 8'h00, 8'h00, 8'h00, 3'b000, 8'h1B, 1'b0, 1'b0, 7'h00, 8'h00, 1'b0, 8'h00);
        step("clrs_q4", CLRF, 12'h063, 8'h00, 8'h00, 8'h00, 3'b011, 8'h1B, 1'b0, 1'b0, 7'h00, 8'h00, 1'b1, 8'h04);

        // MOVWF STATUS goes out on the GPR port only
        step("mws_q2", Q2, 12'h023, 8'h00, 8'hA5, 8'h00, 3'b000, 8'h18, 1'b0, 1'b0, 7'h00, 8'h00, 1'b0, 8'h00);
        step("mws_q4", MOVWF, 12'h023, 8'h00, 8'hA5, 8'h00, 3'b000, 8'h18, 1'b0, 1'b1, 7'h03, 8'hA5, 1'b0, 8'h00);

        // d = 0: flags only, forward entry untouched
        step("d0_q2", Q2, 12'h1CA, 8'h00, 8'h00, 8'h00, 3'b000, 8'h18, 1'b0, 1'b0, 7'h00, 8'h00, 1'b0, 8'h00);
        step("d0_q4", ELSE_S, 12'h1CA, 8'h00, 8'h00, 8'h77, 3'b011, 8'h18, 1'b0, 1'b0, 7'h00, 8'h00, 1'b1, 8'h1B);
        chk("d0.fwdAddr", 32'(fwdAddr), 32'h03);
        chk("d0.fwdData", 32'(fwdData), 32'hA5);

        // Back-to-back Q2/Q4/Q2/Q4
        step("bb_q2a", Q2, 12'h02B, 8'h00, 8'h11, 8'h00, 3'b000, 8'h00, 1'b0, 1'b0, 7'h00, 8'h00, 1'b0, 8'h00);
        step("bb_q4a", MOVWF, 12'h02B, 8'h00, 8'h11, 8'h00, 3'b000, 8'h00, 1'b0, 1'b1, 7'h0B, 8'h11, 1'b0, 8'h00);
        step("bb_q2b", Q2, 12'h030, 8'h35, 8'h00, 8'h00, 3'b000, 8'h00, 1'b0, 1'b0, 7'h00, 8'h00, 1'b0, 8'h00);
        step("bb_q4b", BXF, 12'h030, 8'h35, 8'h00, 8'h22, 3'b000, 8'h00, 1'b0, 1'b1, 7'h30, 8'h22, 1'b0, 8'h00);
        chk("bb.fwdAddr", 32'(fwdAddr), 32'h30);
        chk("bb.orphanErr", 32'(orphanErr), 32'd0);

        // CLRW: Z set, other STATUS bits kept
        step("clrw_q4", CLRW, 12'h040, 8'h00, 8'h00, 8'h00, 3'b000, 8'h1B, 1'b0, 1'b0, 7'h00, 8'h00, 1'b1, 8'h1F);

        // Reset between Q2 and Q4 leaves no pending write
        step("rmid_q2", Q2, 12'h02A, 8'h00, 8'h66, 8'h00, 3'b000, 8'h00, 1'b0, 1'b0, 7'h00, 8'h00, 1'b0, 8'h00);
        do_reset("reset2");
        step("rmid_q4", MOVWF, 12'h02A, 8'h00, 8'h66, 8'h00, 3'b000, 8'h00, 1'b0, 1'b0, 7'h00, 8'h00, 1'b0, 8'h00);
        chk("rmid.orphanErr", 32'(orphanErr), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
